at_latch_rd: RTL

- Read-side companion to the attribute-path enable-latch registers: the counterpart that drains enable-qualified data words to a downstream consumer.
- The writer presents a word with a one-cycle enable. This block buffers it in a small FIFO and presents it on a valid/ready read port.
- A sticky overflow flag records any enable that arrives while the buffer is full.
- Sits between an at_* producer stage and any consumer that can stall.

---
 rtl/at_latch_rd.sv | 107 ++++++++++
 1 files changed

// File: rtl/at_latch_rd.sv
// at_latch_rd: read-side drain buffer for enable-qualified data words.
//
// A producer presents a word on d with a one-cycle enable e. The word is
// stored in a small FIFO and offered to the consumer on a valid/ready port.
// Any enable that arrives while the buffer is full drops the word and sets
// the sticky ovf flag.
//
// Ports:
//   clk      - block clock, all state updates on posedge
//   reset_l  - asynchronous active-low reset
//   e, d     - producer write enable and data
//   rd_ready - consumer accepts rd_d this cycle
//   rd_valid - rd_d holds a valid word
//   rd_d     - oldest buffered word (registered)
//   count    - number of buffered words, 0..depth
//   full     - count == depth
//   ovf      - sticky overflow flag
//   ovf_clr  - synchronous clear of ovf (a same-cycle set wins)
module at_latch_rd #(
  parameter int unsigned size  = 8,
  parameter int unsigned depth = 4,
  parameter int unsigned aw    = 2
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            e,
  input  logic [size-1:0] d,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [size-1:0] rd_d,
  output logic [aw:0]     count,
  output logic            full,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam logic [aw:0] depth_c = (aw+1)'(depth);

  logic [size-1:0] mem [depth];

  logic [aw-1:0] wptr_q, wptr_d;
  logic [aw-1:0] rptr_q, rptr_d;
  logic [aw:0]   count_q, count_d;
  logic [size-1:0] rd_d_q, rd_d_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // full and rd_valid depend on registered count only, so rd_ready never
  // reaches full combinationally.
  assign full     = (count_q == depth_c);
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign rd_d     = rd_d_q;
  assign ovf      = ovf_q;

  always_comb begin
    push    = e && !full;
    pop     = rd_valid && rd_ready;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rd_d_d  = rd_d_q;

    if (push) wptr_d = wptr_q + aw'(1);
    if (pop)  rptr_d = rptr_q + aw'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (aw+1)'(1);
      2'b01:   count_d = count_q - (aw+1)'(1);
      default: count_d = count_q;
    endcase

    // Preload the word that will be at the head after this edge. If the head
    // slot is the one being written right now, forward d instead of the stale
    // array entry. When the buffer goes or stays empty, rd_d keeps its last
    // value so it is never undefined.
    if (count_d != '0) begin
      if (push && (rptr_d == wptr_q)) rd_d_d = d;
      else                            rd_d_d = mem[rptr_d];
    end

    // Overflow set has priority over clear.
    ovf_d = (e && full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rd_d_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rd_d_q  <= rd_d_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= d;
  end

endmodule
